// File: rtl/sm4_pkg.sv
// Shared SM4 constants and linear transforms used by the round-serial encryptor
// and the pipelined decryptor.
package sm4_pkg;

    typedef enum logic [1:0] {
        S_KEY   = 2'd0,
        S_IDLE  = 2'd1,
        S_ROUND = 2'd2
    } sm4_state_e;

    localparam logic [31:0] FK [0:3] = '{
        32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
    };

    // ck_{i,j} = (4i+j)*7 mod 256, packed big-endian per word
    localparam logic [31:0] CK [0:31] = '{
        32'h00070E15, 32'h1C232A31, 32'h383F464D, 32'h545B6269,
        32'h70777E85, 32'h8C939AA1, 32'hA8AFB6BD, 32'hC4CBD2D9,
        32'hE0E7EEF5, 32'hFC030A11, 32'h181F262D, 32'h343B4249,
        32'h50575E65, 32'h6C737A81, 32'h888F969D, 32'hA4ABB2B9,
        32'hC0C7CED5, 32'hDCE3EAF1, 32'hF8FF060D, 32'h141B2229,
        32'h30373E45, 32'h4C535A61, 32'h686F767D, 32'h848B9299,
        32'hA0A7AEB5, 32'hBCC3CAD1, 32'hD8DFE6ED, 32'hF4FB0209,
        32'h10171E25, 32'h2C333A41, 32'h484F565D, 32'h646B7279
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
        8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
        8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
        8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
        8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
        8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
        8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
        8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
        8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
        8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
        8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
        8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
        8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
        8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
    };

    // Round linear transform L
    function automatic logic [31:0] L(input logic [31:0] b);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0],  b[31:8]};
    endfunction

    // Key-schedule linear transform L'
    function automatic logic [31:0] L_key(input logic [31:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

endpackage

// File: rtl/sm4_tau.sv
// Combinational SM4 non-linear transform: four parallel S-box lookups.
module sm4_tau
    import sm4_pkg::*;
(
    input  logic [31:0] a_i,
    output logic [31:0] b_o
);

    assign b_o = {SBOX[a_i[31:24]], SBOX[a_i[23:16]], SBOX[a_i[15:8]], SBOX[a_i[7:0]]};

endmodule

// File: rtl/sm4_encrypt_iter.sv
// Round-serial SM4 encryptor: expands the master key into a 32-entry round-key file,
// then encrypts one block per 33 cycles through a single shared tau datapath.
module sm4_encrypt_iter
    import sm4_pkg::*;
#(
    parameter logic [127:0] P_INITIAL_KEY = 128'h000102030405060708090A0B0C0D0E0F
)(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [127:0] i_key,
    input  logic         i_key_valid,
    input  logic [127:0] i_axis_data,
    input  logic         i_axis_valid,
    output logic         o_axis_ready,
    output logic [127:0] o_axim_data,
    output logic         o_axim_valid,
    output logic         o_key_done
);

    localparam logic [127:0] FK_WORDS = {FK[0], FK[1], FK[2], FK[3]};

    sm4_state_e   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [127:0] k_q, k_d;
    logic [127:0] x_q, x_d;
    logic [31:0]  rk_q [0:31];
    logic         ready_q, ready_d;
    logic         valid_q, valid_d;
    logic [127:0] data_q, data_d;
    logic         key_done_q, key_done_d;

    logic         rk_we_s;
    logic [31:0]  tau_in_s, tau_out_s;
    logic [31:0]  key_new_s, rnd_new_s;

    // Operand select for the shared tau: key schedule while expanding, rounds otherwise
    always_comb begin
        tau_in_s = 32'h0;
        if (state_q == S_KEY) begin
            tau_in_s = k_q[95:64] ^ k_q[63:32] ^ k_q[31:0] ^ CK[cnt_q];
        end else begin
            tau_in_s = x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ rk_q[cnt_q];
        end
    end

    sm4_tau u_tau (
        .a_i (tau_in_s),
        .b_o (tau_out_s)
    );

    assign key_new_s = k_q[127:96] ^ L_key(tau_out_s);
    assign rnd_new_s = x_q[127:96] ^ L(tau_out_s);

    // Next-state and output logic; a key load overrides everything, aborting any block
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        x_d        = x_q;
        ready_d    = ready_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        key_done_d = key_done_q;
        rk_we_s    = 1'b0;
        if (i_key_valid) begin
            k_d        = i_key ^ FK_WORDS;
            cnt_d      = 5'd0;
            state_d    = S_KEY;
            key_done_d = 1'b0;
            ready_d    = 1'b0;
        end else begin
            case (state_q)
                S_KEY: begin
                    rk_we_s = 1'b1;
                    k_d     = {k_q[95:0], key_new_s};
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d    = S_IDLE;
                        key_done_d = 1'b1;
                        ready_d    = 1'b1;
                    end else begin
                        state_d    = S_KEY;
                    end
                end
                S_IDLE: begin
                    if (i_axis_valid && ready_q) begin
                        x_d     = i_axis_data;
                        cnt_d   = 5'd0;
                        state_d = S_ROUND;
                        ready_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ROUND: begin
                    x_d   = {x_q[95:0], rnd_new_s};
                    cnt_d = cnt_q + 5'd1;
                    // Final round: reverse word order R into the output register
                    if (cnt_q == 5'd31) begin
                        data_d  = {rnd_new_s, x_q[31:0], x_q[63:32], x_q[95:64]};
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                    end else begin
                        state_d = S_ROUND;
                    end
                end
                default: begin
                    state_d    = S_KEY;
                    cnt_d      = 5'd0;
                    ready_d    = 1'b0;
                    key_done_d = 1'b0;
                end
            endcase
        end
    end

    // Control, working registers and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_KEY;
            cnt_q      <= 5'd0;
            k_q        <= P_INITIAL_KEY ^ FK_WORDS;
            x_q        <= 128'h0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= 128'h0;
            key_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            x_q        <= x_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            key_done_q <= key_done_d;
        end
    end

    // Round-key register file, written one entry per key-expansion cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) begin
                rk_q[i] <= 32'h0;
            end
        end else if (rk_we_s) begin
            rk_q[cnt_q] <= key_new_s;
        end
    end

    assign o_axis_ready = ready_q;
    assign o_axim_valid = valid_q;
    assign o_axim_data  = data_q;
    assign o_key_done   = key_done_q;

endmodule

// File: tb/tb_sm4_encrypt_iter.sv
// Randomized self-checking bench for sm4_encrypt_iter against a word-list SM4 model.
module tb_sm4_encrypt_iter;
    import sm4_pkg::SBOX;

    localparam logic [127:0] INIT_KEY = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] STD_VEC  = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] STD_CT   = 128'h681EDF34D206965E86B3E94F536E4246;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [127:0] i_key;
    logic         i_key_valid;
    logic [127:0] i_axis_data;
    logic         i_axis_valid;
    logic         o_axis_ready;
    logic [127:0] o_axim_data;
    logic         o_axim_valid;
    logic         o_key_done;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_rk [0:31];

    always #5 i_clk = ~i_clk;

    sm4_encrypt_iter dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_key        (i_key),
        .i_key_valid  (i_key_valid),
        .i_axis_data  (i_axis_data),
        .i_axis_valid (i_axis_valid),
        .o_axis_ready (o_axis_ready),
        .o_axim_data  (o_axim_data),
        .o_axim_valid (o_axim_valid),
        .o_key_done   (o_key_done)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] tau_m(input logic [31:0] v);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = SBOX[v[8*b +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Key schedule straight from the algorithm definition: K[i+4] = K[i] ^ T'(...)
    task automatic model_expand(input logic [127:0] mk);
        logic [31:0] k [0:35];
        logic [31:0] fk [0:3];
        logic [31:0] ck, t;
        fk = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
        for (int i = 0; i < 4; i++) k[i] = mk[127 - 32*i -: 32] ^ fk[i];
        for (int i = 0; i < 32; i++) begin
            ck = 32'h0;
            for (int j = 0; j < 4; j++) ck = (ck << 8) | 32'(((4*i + j) * 7) % 256);
            t = tau_m(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            k[i+4] = k[i] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
            m_rk[i] = k[i+4];
        end
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [31:0] x [0:35];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) x[i] = pt[127 - 32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            t = tau_m(x[i+1] ^ x[i+2] ^ x[i+3] ^ m_rk[i]);
            x[i+4] = x[i] ^ t ^ rotl(t, 2) ^ rotl(t, 10) ^ rotl(t, 18) ^ rotl(t, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // Count edges until o_axis_ready, also counting any output pulses seen meanwhile
    task automatic wait_ready(output int n, output int nv);
        n = 0; nv = 0;
        while (!o_axis_ready && n < 200) begin
            @(posedge i_clk); #1;
            n++;
            if (o_axim_valid) nv++;
        end
    endtask

    task automatic load_key(input logic [127:0] k, input int hold);
        int n, nv;
        for (int h = 0; h < hold; h++) begin
            @(negedge i_clk);
            i_key = (h == hold - 1) ? k : rand128();
            i_key_valid = 1'b1;
            @(posedge i_clk);
        end
        #1 i_key_valid = 1'b0;
        check_eq("key_done_drop", 128'(o_key_done), 128'd0);
        check_eq("ready_drop", 128'(o_axis_ready), 128'd0);
        wait_ready(n, nv);
        check_eq("key_latency", 128'(n), 128'd32);
        check_eq("key_stray_valid", 128'(nv), 128'd0);
        check_eq("key_done_rise", 128'(o_key_done), 128'd1);
        model_expand(k);
    endtask

    // One handshake, then junk on the input with valid held while busy (must be ignored)
    task automatic send_block(input logic [127:0] pt, output logic [127:0] ct, output int lat);
        check_eq("ready_before_hs", 128'(o_axis_ready), 128'd1);
        @(negedge i_clk);
        i_axis_data = pt;
        i_axis_valid = 1'b1;
        @(posedge i_clk); #1;
        i_axis_data = rand128();
        lat = 0;
        while (!o_axim_valid && lat < 100) begin
            @(posedge i_clk); #1;
            lat++;
            if (lat == 20) i_axis_valid = 1'b0;
        end
        i_axis_valid = 1'b0;
        ct = o_axim_data;
        check_eq("ready_after_out", 128'(o_axis_ready), 128'd1);
        @(posedge i_clk); #1;
        check_eq("valid_one_cycle", 128'(o_axim_valid), 128'd0);
        check_eq("data_held", o_axim_data, ct);
    endtask

    task automatic enc_check(input string tag, input logic [127:0] pt);
        logic [127:0] ct;
        int lat;
        send_block(pt, ct, lat);
        check_eq({tag, "_lat"}, 128'(lat), 128'd32);
        check_eq({tag, "_ct"}, ct, model_enc(pt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] ct, pts [0:3], cts [0:3];
        int n, nv, lat, nhs, nout, hs_edge [0:3], out_edge [0:3];
        logic prev_ready;

        i_rst = 1'b1; i_key = 128'h0; i_key_valid = 1'b0;
        i_axis_data = 128'h0; i_axis_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_eq("rst_ready", 128'(o_axis_ready), 128'd0);
        check_eq("rst_valid", 128'(o_axim_valid), 128'd0);
        check_eq("rst_data", o_axim_data, 128'd0);
        check_eq("rst_key_done", 128'(o_key_done), 128'd0);
        @(negedge i_clk) i_rst = 1'b0;
        wait_ready(n, nv);
        check_eq("rst_key_latency", 128'(n), 128'd32);
        check_eq("rst_key_done_rise", 128'(o_key_done), 128'd1);

        // All-zero block under the power-on key
        model_expand(INIT_KEY);
        enc_check("zero_blk", 128'h0);

        // Standard known-answer vector
        load_key(STD_VEC, 1);
        check_eq("model_rk0", 128'(m_rk[0]), 128'h00000000_00000000_00000000_F12186F9);
        check_eq("model_rk31", 128'(m_rk[31]), 128'h00000000_00000000_00000000_9124A012);
        check_eq("model_std", model_enc(STD_VEC), STD_CT);
        send_block(STD_VEC, ct, lat);
        check_eq("std_lat", 128'(lat), 128'd32);
        check_eq("std_ct", ct, STD_CT);

        // Back-to-back: valid held high across four blocks
        for (int b = 0; b < 4; b++) pts[b] = rand128();
        nhs = 0; nout = 0;
        @(negedge i_clk);
        i_axis_data = pts[0];
        i_axis_valid = 1'b1;
        prev_ready = o_axis_ready;
        for (int cyc = 0; cyc < 150; cyc++) begin
            @(posedge i_clk);
            if (prev_ready && i_axis_valid && nhs < 4) begin
                hs_edge[nhs] = cyc;
                nhs++;
                #1;
                if (nhs < 4) i_axis_data = pts[nhs];
                else i_axis_valid = 1'b0;
            end else begin
                #1;
            end
            if (o_axim_valid) begin
                if (nout < 4) begin
                    out_edge[nout] = cyc;
                    cts[nout] = o_axim_data;
                end
                nout++;
            end
            prev_ready = o_axis_ready;
        end
        i_axis_valid = 1'b0;
        check_eq("b2b_handshakes", 128'(nhs), 128'd4);
        check_eq("b2b_valid_cycles", 128'(nout), 128'd4);
        if (nhs == 4 && nout == 4) begin
            for (int b = 0; b < 4; b++) begin
                check_eq("b2b_hs_edge", 128'(hs_edge[b] - hs_edge[0]), 128'(33 * b));
                check_eq("b2b_latency", 128'(out_edge[b] - hs_edge[b]), 128'd32);
                check_eq("b2b_ct", cts[b], model_enc(pts[b]));
            end
        end

        // Key reload during round 10 aborts the block
        @(negedge i_clk);
        i_axis_data = rand128();
        i_axis_valid = 1'b1;
        @(posedge i_clk); #1;
        i_axis_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        load_key(rand128(), 1);
        enc_check("after_abort", rand128());

        // Key load coincident with a handshake: block dropped
        @(negedge i_clk);
        i_axis_data = rand128();
        i_axis_valid = 1'b1;
        i_key = rand128();
        i_key_valid = 1'b1;
        ct = i_key;
        @(posedge i_clk); #1;
        i_axis_valid = 1'b0;
        i_key_valid = 1'b0;
        check_eq("coinc_key_done", 128'(o_key_done), 128'd0);
        wait_ready(n, nv);
        check_eq("coinc_latency", 128'(n), 128'd32);
        check_eq("coinc_no_output", 128'(nv), 128'd0);
        model_expand(ct);
        enc_check("coinc_next", rand128());

        // Random keys (some held several cycles) with random idle gaps
        for (int r = 0; r < 4; r++) begin
            load_key(rand128(), 1 + r);
            for (int b = 0; b < 3; b++) begin
                repeat ($urandom_range(0, 5)) @(posedge i_clk);
                #1;
                enc_check("rand", rand128());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sm4_encrypt_iter.md
# sm4_encrypt_iter

Round-serial SM4 (GB/T 32907) block encryptor, the transmit-side counterpart of the pipelined SM4 decryptor. It expands one 128-bit master key into 32 round keys held in a register file, then encrypts one 128-bit block at a time over 32 clock cycles. It reuses a single τ (four S-boxes) datapath for both key expansion and rounds. It trades the decryptor's throughput for about 1/32 of the logic, and sits on the TX side of the link feeding the same AXI-Stream style data path.

## Interface
- P_INITIAL_KEY, 128'h000102030405060708090A0B0C0D0E0F, master key expanded automatically after reset.
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_key  in  128  new master key MK, sampled when i_key_valid=1.
- i_key_valid  in  1  one-cycle key load strobe; restarts key expansion.
- i_axis_data  in  128  plaintext block, word X0 in [127:96].
- i_axis_valid  in  1  plaintext valid.
- o_axis_ready  out  1  registered; high only in S_IDLE.
- o_axim_data  out  128  ciphertext {Y0,Y1,Y2,Y3}, Y0 in [127:96]; holds its value between outputs.
- o_axim_valid  out  1  one-cycle pulse per ciphertext; no backpressure.
- o_key_done  out  1  level; high once all 32 round keys are valid for the current key.

## Operation
- FSM states are S_KEY, S_IDLE and S_ROUND. A 5-bit counter cnt is shared between S_KEY and S_ROUND.
- Reset values:
  - state=S_KEY, cnt=0, K regs = P_INITIAL_KEY ^ FK.
  - rk[0..31]=0.
  - o_axis_ready=0, o_axim_valid=0, o_axim_data=0, o_key_done=0.
- S_KEY, each cycle:
  - rk[cnt] <= K0 ^ L'(τ(K1^K2^K3^CK[cnt])).
  - {K0..K3} <= {K1,K2,K3,new}.
  - cnt++.
  - When cnt=31, go to S_IDLE and set o_key_done=1 and o_axis_ready=1.
- S_IDLE: a handshake (i_axis_valid & o_axis_ready) loads X0..X3 and sets cnt=0. State goes to S_ROUND and o_axis_ready goes to 0.
- S_ROUND, each cycle:
  - new = X0 ^ L(τ(X1^X2^X3^rk[cnt])).
  - Shift {X0..X3} <= {X1,X2,X3,new}.
  - cnt++.
  - At cnt=31, register o_axim_data = {new, X3, X2, X1} (reverse transform R) and pulse o_axim_valid.
  - In the same cycle, return to S_IDLE and set o_axis_ready=1.
- L(B) = B ^ (B<<<2) ^ (B<<<10) ^ (B<<<18) ^ (B<<<24).
- L'(B) = B ^ (B<<<13) ^ (B<<<23).
- τ input mux: K-path in S_KEY, X-path otherwise.
- i_key_valid in any state has priority over everything else:
  - K <= i_key ^ FK, cnt=0, state=S_KEY.
  - o_key_done=0, o_axis_ready=0.
  - Any in-flight block is aborted with no o_axim_valid.
  - If i_key_valid is held for several cycles, expansion restarts every cycle; the last key wins.
- i_key_valid coincident with a handshake in S_IDLE: the block counts as consumed and is discarded; no output is produced.
- i_axis_valid while o_axis_ready=0 is ignored. The data is not captured.
- cnt wraps 31→0 naturally. No other terminal handling is needed.

## Timing
- Key expansion latency is 32 cycles:
  - after reset deassertion, o_key_done and o_axis_ready rise at the 32nd rising edge;
  - after an i_key_valid edge, they rise 32 edges later.
- Block latency: handshake sampled at edge E0 → o_axim_valid high after edge E32 (32 cycles), for exactly one cycle.
- o_axis_ready reasserts at E32, so the earliest next handshake is E33. Throughput is 1 block / 33 cycles.
- All outputs are registered. The critical path is the XOR3 → S-box → L → XOR chain, one round per cycle.

## Structure
- Package sm4_pkg holds:
  - FK[0:3] = A3B1BAC6, 56AA3350, 677D9197, B27022DC;
  - CK[0:31] constant table (ck_{i,j} = (4i+j)*7 mod 256);
  - SBOX[0:255] table;
  - functions L and L_key.
- The package is shared with the decryptor.
- Sub-module sm4_tau: combinational 32-bit τ (four sm4_pkg SBOX lookups), instantiated once.

## Test plan
- Standard vector:
  - stimulus: i_key = i_axis_data = 0123456789ABCDEFFEDCBA9876543210;
  - required: rk[0]=F12186F9, rk[31]=9124A012;
  - required: o_axim_data=681EDF34D206965E86B3E94F536E4246 exactly 32 cycles after the handshake.
- Reset:
  - o_axis_ready=0 until the 32nd edge after reset release, then 1;
  - encrypt the all-zero block under P_INITIAL_KEY and compare against the C golden model.
- Back-to-back: i_axis_valid held high with 4 blocks → handshakes at E0, E33, E66, E99; 4 single-cycle o_axim_valid pulses with correct ciphertexts.
- Key reload mid-block:
  - apply i_key_valid at round 10 → no o_axim_valid for that block;
  - o_axis_ready returns 32 cycles later;
  - the next block is encrypted under the new key.
- Coincident key load and handshake in S_IDLE:
  - block dropped, no output;
  - o_key_done drops for 32 cycles.
- Iterated vector (long regression): feed each ciphertext back as the next plaintext under key 0123…3210 for 1,000,000 iterations → final 595298C7C6FD271F0402F804C33D3F66.
